// File: rtl/fir_axis_out_buffer.sv
// Output buffer behind the FIR core: a small first-word-fall-through FIFO that
// absorbs sink back-pressure, re-presents samples on an AXI-Stream master,
// checks tlast placement against the programmed frame length and pulses
// frame_done when the end-of-frame beat leaves the buffer.
module fir_axis_out_buffer #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 8,
    parameter int pLEN_WIDTH  = 10
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,
    input  logic                     s_tvalid,
    input  logic [pDATA_WIDTH-1:0]   s_tdata,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic                     m_tvalid,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic                     m_tlast,
    input  logic                     m_tready,
    input  logic [pLEN_WIDTH-1:0]    cfg_length,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_done,
    output logic                     tlast_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    typedef struct packed {
        logic                   last;
        logic [pDATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                 mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [pLEN_WIDTH-1:0]  scnt_q, scnt_d;
    logic [pLEN_WIDTH-1:0]  len_q, len_d;
    logic                   tlast_err_q, tlast_err_d;
    logic                   frame_done_q, frame_done_d;

    logic                   push;
    logic                   pop;
    entry_t                 head;
    logic [pLEN_WIDTH-1:0]  len_eff;
    logic [pLEN_WIDTH-1:0]  scnt_inc;

    assign level      = level_q;
    assign frame_done = frame_done_q;
    assign tlast_err  = tlast_err_q;

    // Handshakes and fall-through output, all derived from registered occupancy.
    always_comb begin
        s_tready = (level_q != FULL_LEVEL) && !clear;
        m_tvalid = (level_q != '0);
        push     = s_tvalid && s_tready;
        pop      = m_tvalid && m_tready && !clear;
        head     = mem_q[rd_ptr_q];
        m_tdata  = m_tvalid ? head.data : '0;
        m_tlast  = m_tvalid && head.last;
    end

    // Pointer, occupancy and frame_done next-state; clear overrides everything.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        frame_done_d = pop && head.last;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            frame_done_d = 1'b0;
        end
    end

    // Framing checker: count accepted samples and compare tlast with the frame length.
    always_comb begin
        scnt_d      = scnt_q;
        len_d       = len_q;
        tlast_err_d = tlast_err_q;
        // The first sample of a frame uses cfg_length directly, as it is latched on that push.
        len_eff     = (scnt_q == '0) ? cfg_length : len_q;
        scnt_inc    = scnt_q + pLEN_WIDTH'(1);
        if (push) begin
            if (scnt_q == '0) begin
                len_d = cfg_length;
            end
            if (s_tlast) begin
                if ((len_eff == '0) || (scnt_inc != len_eff)) begin
                    tlast_err_d = 1'b1;
                end
                scnt_d = '0;
            end else if ((len_eff == '0) || (scnt_inc == len_eff)) begin
                tlast_err_d = 1'b1;
                scnt_d      = '0;
            end else begin
                scnt_d = scnt_inc;
            end
        end
        if (clear) begin
            scnt_d      = '0;
            tlast_err_d = 1'b0;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (axis_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            scnt_q       <= '0;
            len_q        <= '0;
            tlast_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            scnt_q       <= scnt_d;
            len_q        <= len_d;
            tlast_err_q  <= tlast_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Sample storage written on each accepted input beat.
    always_ff @(posedge axis_clk) begin
        // NOTE: storage has no reset; level==0 masks stale entries, so it can map to plain RAM.
        if (push) begin
            mem_q[wr_ptr_q] <= '{last: s_tlast, data: s_tdata};
        end
    end

endmodule

// File: tb/tb_fir_axis_out_buffer.sv
// Bench for fir_axis_out_buffer: a queue-based model of the buffer and framing
// rules is compared against the DUT every cycle, and directed scenarios add
// hand-computed literal expectations.
module tb_fir_axis_out_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = 10;

    logic              axis_clk = 1'b0;
    logic              axis_rst = 1'b1;
    logic              s_tvalid = 1'b0;
    logic [DW-1:0]     s_tdata  = '0;
    logic              s_tlast  = 1'b0;
    logic              s_tready;
    logic              m_tvalid;
    logic [DW-1:0]     m_tdata;
    logic              m_tlast;
    logic              m_tready = 1'b0;
    logic [LW-1:0]     cfg_length = '0;
    logic              clear = 1'b0;
    logic [3:0]        level;
    logic              frame_done;
    logic              tlast_err;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    fir_axis_out_buffer #(
        .pDATA_WIDTH(DW),
        .DEPTH      (DEPTH),
        .pLEN_WIDTH (LW)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .s_tvalid  (s_tvalid),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .cfg_length(cfg_length),
        .clear     (clear),
        .level     (level),
        .frame_done(frame_done),
        .tlast_err (tlast_err)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          last;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   pos  = 0;
    int   mlen = 0;
    bit   merr = 1'b0;
    bit   mfd  = 1'b0;
    bit   do_push, do_pop;

    always @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            mq.delete();
            pos  = 0;
            mlen = 0;
            merr = 1'b0;
            mfd  = 1'b0;
        end else if (clear) begin
            mq.delete();
            pos  = 0;
            merr = 1'b0;
            mfd  = 1'b0;
        end else begin
            do_push = s_tvalid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && m_tready;
            mfd = 1'b0;
            if (do_pop) begin
                mfd = mq[0].last;
                void'(mq.pop_front());
            end
            if (do_push) begin
                if (pos == 0) mlen = int'(cfg_length);
                pos++;
                mq.push_back('{s_tlast, s_tdata});
                if (s_tlast) begin
                    if (pos != mlen) merr = 1'b1;
                    pos = 0;
                end else if (mlen == 0 || pos == mlen) begin
                    merr = 1'b1;
                    pos  = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    bit            exp_valid;
    logic [DW-1:0] exp_data;
    bit            exp_last;
    always @(negedge axis_clk) begin
        if (run_cmp) begin
            exp_valid = (mq.size() != 0);
            exp_data  = exp_valid ? mq[0].data : '0;
            exp_last  = exp_valid ? mq[0].last : 1'b0;
            check("m_tvalid",   64'(m_tvalid),   64'(exp_valid));
            check("m_tdata",    64'(m_tdata),    64'(exp_data));
            check("m_tlast",    64'(m_tlast),    64'(exp_last));
            check("level",      64'(level),      64'(mq.size()));
            check("s_tready",   64'(s_tready),   64'((mq.size() != DEPTH) && !clear));
            check("frame_done", 64'(frame_done), 64'(mfd));
            check("tlast_err",  64'(tlast_err),  64'(merr));
        end
    end

    // Log of data actually leaving the DUT.
    logic [DW-1:0] out_log[$];
    always @(negedge axis_clk) begin
        if (!axis_rst && m_tvalid && m_tready && !clear) out_log.push_back(m_tdata);
    end

    // ---------------- stimulus helpers (enter and leave at posedge+1) ----------------
    task automatic send(input logic [DW-1:0] d, input logic l);
        int waited = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        #1;
        while (!s_tready && waited <= 50) begin
            @(posedge axis_clk);
            #2;
            waited++;
        end
        if (waited > 50) begin
            errors++;
            $display("FAIL send timeout: sample %0h not accepted within 50 cycles", d);
        end
        @(posedge axis_clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge axis_clk);
        #1;
        clear = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        #12 axis_rst = 1'b0;
        @(posedge axis_clk);
        #1;
        run_cmp = 1'b1;

        // Reset state.
        check("rst m_tvalid",  64'(m_tvalid),  64'd0);
        check("rst m_tdata",   64'(m_tdata),   64'd0);
        check("rst s_tready",  64'(s_tready),  64'd1);
        check("rst level",     64'(level),     64'd0);
        check("rst tlast_err", 64'(tlast_err), 64'd0);

        // Simple frame of 4 with the sink always ready.
        cfg_length = 10'd4;
        m_tready   = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i), i == 4);
            check("t1 data", 64'(m_tdata), 64'(i));
            check("t1 last", 64'(m_tlast), 64'(i == 4));
        end
        idle(1);
        check("t1 frame_done", 64'(frame_done), 64'd1);
        check("t1 level", 64'(level), 64'd0);
        idle(1);
        check("t1 frame_done off", 64'(frame_done), 64'd0);
        check("t1 tlast_err", 64'(tlast_err), 64'd0);

        // Fill to full with the sink stalled, then drain.
        out_log.delete();
        m_tready = 1'b0;
        for (int i = 1; i <= 8; i++) send(DW'(100 + i), 1'b0);
        check("t2 full level", 64'(level), 64'd8);
        check("t2 full s_tready", 64'(s_tready), 64'd0);
        s_tvalid = 1'b1;
        s_tdata  = DW'(109);
        s_tlast  = 1'b0;
        repeat (2) @(posedge axis_clk);
        #1;
        check("t2 held level", 64'(level), 64'd8);
        m_tready = 1'b1;
        send(DW'(109), 1'b0);
        send(DW'(110), 1'b0);
        idle(12);
        check("t2 out count", 64'(out_log.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < out_log.size()) check("t2 out order", 64'(out_log[i]), 64'(101 + i));
        end

        // Steady state at level 3 with simultaneous push and pop.
        pulse_clear();
        out_log.delete();
        m_tready = 1'b0;
        for (int i = 1; i <= 3; i++) send(DW'(200 + i), 1'b0);
        check("t3 level", 64'(level), 64'd3);
        m_tready = 1'b1;
        for (int i = 4; i <= 23; i++) begin
            send(DW'(200 + i), 1'b0);
            check("t3 level steady", 64'(level), 64'd3);
        end
        idle(5);
        check("t3 out count", 64'(out_log.size()), 64'd23);
        for (int i = 0; i < 23; i++) begin
            if (i < out_log.size()) check("t3 out order", 64'(out_log[i]), 64'(201 + i));
        end

        // Early tlast, then a correct frame: error stays set.
        pulse_clear();
        check("t4 err cleared", 64'(tlast_err), 64'd0);
        cfg_length = 10'd4;
        send(DW'(1), 1'b0);
        send(DW'(2), 1'b0);
        check("t4 err before", 64'(tlast_err), 64'd0);
        send(DW'(3), 1'b1);
        check("t4 early tlast", 64'(tlast_err), 64'd1);
        for (int i = 1; i <= 4; i++) send(DW'(10 + i), i == 4);
        check("t4 sticky", 64'(tlast_err), 64'd1);
        idle(3);

        // Missing tlast.
        pulse_clear();
        cfg_length = 10'd3;
        send(DW'(21), 1'b0);
        send(DW'(22), 1'b0);
        check("t5 err before", 64'(tlast_err), 64'd0);
        send(DW'(23), 1'b0);
        check("t5 missing tlast", 64'(tlast_err), 64'd1);
        idle(3);

        // Zero length flags on the first push; clear with s_tvalid held.
        pulse_clear();
        cfg_length = 10'd0;
        m_tready   = 1'b0;
        send(DW'(31), 1'b1);
        check("t6 len0 err", 64'(tlast_err), 64'd1);
        for (int i = 2; i <= 5; i++) send(DW'(30 + i), 1'b0);
        check("t6 level5", 64'(level), 64'd5);
        s_tvalid = 1'b1;
        s_tdata  = DW'(99);
        clear    = 1'b1;
        #1;
        check("t6 clear s_tready", 64'(s_tready), 64'd0);
        @(posedge axis_clk);
        #1;
        clear    = 1'b0;
        s_tvalid = 1'b0;
        check("t6 clear level", 64'(level), 64'd0);
        check("t6 clear m_tvalid", 64'(m_tvalid), 64'd0);
        check("t6 clear err", 64'(tlast_err), 64'd0);

        // Asynchronous reset mid-frame.
        cfg_length = 10'd4;
        send(DW'(41), 1'b0);
        send(DW'(42), 1'b0);
        send(DW'(43), 1'b1);
        check("t7 pre-rst err", 64'(tlast_err), 64'd1);
        m_tready = 1'b1;
        axis_rst = 1'b1;
        #1;
        check("t7 rst m_tvalid", 64'(m_tvalid), 64'd0);
        check("t7 rst m_tdata", 64'(m_tdata), 64'd0);
        check("t7 rst level", 64'(level), 64'd0);
        check("t7 rst err", 64'(tlast_err), 64'd0);
        check("t7 rst frame_done", 64'(frame_done), 64'd0);
        @(negedge axis_clk);
        #1 axis_rst = 1'b0;
        out_log.delete();
        idle(4);
        check("t7 no beats after rst", 64'(out_log.size()), 64'd0);
        check("t7 s_tready", 64'(s_tready), 64'd1);

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
